// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-port logic.
package rf_pkg;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  // r0 is hard-wired zero; writes aimed at it are swallowed.
  localparam logic [AW-1:0] ADDR_ZERO = '0;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: search starts one past the last grant.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);
  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    for (int off = N; off >= 1; off--) begin
      j = (int'(i_last) + off) % N;
      if (i_req[j]) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = PW'(j);
        o_any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter with a clear sequencer for r1..r31.
module rf_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              RFWr,
  output logic [AW-1:0]     A3,
  output logic [DW-1:0]     WD
);
  import rf_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_rr_ptr;
  logic [AW-1:0]   r_clr_idx;
  logic            r_rfwr;
  logic [AW-1:0]   r_a3;
  logic [DW-1:0]   r_wd;

  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic            w_xfer;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .i_req  (req_valid),
    .i_last (r_rr_ptr),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_addr = req_addr[int'(w_idx)*AW +: AW];
  assign w_data = req_data[int'(w_idx)*DW +: DW];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, grant and busy; a clear request masks all grants that cycle.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    clear_busy  = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_start) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          req_ready = w_gnt;
          w_xfer    = w_any;
        end
      end
      ST_CLEAR: begin
        clear_busy = 1'b1;
        if (r_clr_idx == LAST_REG) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!rst_n) begin
      req_ready = '0;
      w_xfer    = 1'b0;
    end
  end

  // Round-robin pointer, clear index and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr  <= PW'(NREQ - 1);
      r_clr_idx <= '0;
      r_rfwr    <= 1'b0;
      r_a3      <= '0;
      r_wd      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rfwr <= 1'b0;
          if (clear_start) begin
            r_clr_idx <= AW'(1);
          end else if (w_xfer) begin
            r_rr_ptr <= w_idx;
            if (w_addr != ADDR_ZERO) begin
              r_rfwr <= 1'b1;
              r_a3   <= w_addr;
              r_wd   <= w_data;
            end
          end
        end
        ST_CLEAR: begin
          r_rfwr    <= 1'b1;
          r_a3      <= r_clr_idx;
          r_wd      <= '0;
          r_clr_idx <= (r_clr_idx == LAST_REG) ? '0 : r_clr_idx + AW'(1);
        end
        default: r_rfwr <= 1'b0;
      endcase
    end
  end

  assign RFWr = r_rfwr;
  assign A3   = r_a3;
  assign WD   = r_wd;
endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Shares the register file's single write port (RFWr/A3/WD) among NREQ writeback requesters: CPU writeback, load-return path and debug monitor. Round-robin arbitration uses per-requester valid/ready handshakes. A clear sequencer zeroes r1..r31 on command. The block sits between the writeback sources and the register file, and drives the register-file write inputs from registers.

## Interface
- NREQ, 3, number of requesters (2..4); index 0 = CPU writeback
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed target register, requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot-or-zero grant; transfer when valid&ready
- clear_start  in  1  single-cycle pulse: zero r1..r31
- clear_busy  out  1  high while clear sequence runs
- RFWr  out  1  register-file write enable (registered)
- A3  out  AW  register-file write address (registered)
- WD  out  DW  register-file write data (registered)

## Operation
- FSM states: IDLE, CLEAR.
- IDLE:
  - round-robin pick among asserted req_valid, starting at rr_ptr+1 mod NREQ.
  - winner's req_ready=1; all other ready bits 0.
  - On transfer: rr_ptr<=winner; next cycle RFWr=1, A3=addr, WD=data.
  - If the granted addr==0: transfer completes and rr_ptr advances, but RFWr stays 0 (r0 is hard-wired zero).
  - No valid: RFWr=0; A3/WD hold their previous values.
- req_ready is combinational from req_valid and rr_ptr. Requesters hold valid/addr/data stable until ready; deasserting valid before the grant is legal and drops the request.
- IDLE & clear_start: go to CLEAR. All req_ready are 0 that cycle; clear takes priority over pending requests. clr_idx<=1.
- CLEAR:
  - each cycle: RFWr=1, A3=clr_idx, WD=0, clr_idx++; all req_ready=0.
  - after issuing clr_idx=31, return to IDLE. rr_ptr is unchanged.
  - clear_start while in CLEAR is ignored.
- clear_busy=1 in every CLEAR cycle, including the cycle that issues r31.
- Throughput: one register write per clock; no write is ever lost or duplicated.

## Timing
- Reset values (rst_n=0 at a rising edge):
  - state=IDLE, rr_ptr=NREQ-1 (requester 0 wins first)
  - RFWr=0, A3=0, WD=0, clr_idx=0, clear_busy=0, req_ready=0
- Reset mid-CLEAR aborts immediately; the remaining registers are not cleared.
- Latency: transfer at edge N gives RFWr/A3/WD valid from edge N to edge N+1. The register file samples them at the intervening falling edge.
- Back-to-back grants to different requesters: RFWr stays high continuously.
- CLEAR takes exactly 31 cycles. clear_start sampled at edge N produces writes to r1 through r31 in cycles N+1..N+31; IDLE grants resume from edge N+31.
- Writes are ordered and immediate. A read of the same register is visible after the falling edge that follows the RFWr cycle.

## Structure
- Shared package rf_pkg holds:
  - AW, DW and NREG=32 constants
  - state enum (ST_IDLE, ST_CLEAR)
  - ADDR_ZERO constant
- Sub-module rr_pick: purely combinational round-robin selector. Inputs: req vector and last-grant pointer. Outputs: one-hot grant, encoded index and any_grant flag. It is reusable by the future RF read-port arbiter.
- Top level contains the FSM, rr_ptr, clr_idx and the output registers.

## Test plan
- Reset then single request: req_valid=3'b001, addr=5, data=0x1234_5678. Required: req_ready=001 that cycle; next cycle RFWr=1, A3=5, WD=0x12345678; register 5 reads back 0x12345678.
- Three requesters held valid continuously: grants in order 0,1,2,0,1,2. RFWr is high in every cycle and A3/WD match each winner's addr/data.
- Requester 1 writes addr=0, data=0xFFFF_FFFF: ready given and rr_ptr advances to 1. RFWr stays 0 and register 0 reads 0.
- clear_start with all three requesters valid in the same cycle: no ready for 31 cycles. A3 steps 1..31 with WD=0 and clear_busy=1 throughout; then grants resume.
- Assert rst_n=0 during the 10th cycle of CLEAR: next edge RFWr=0, clear_busy=0, state=IDLE. Registers 11..31 keep their prior nonzero values.
- Requester 2 drops valid before being granted while requester 0 stays valid: requester 2 is never granted. No write to requester 2's address occurs.
